// File: rtl/ram_block_summer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_block_summer
//  Purpose  : Controller that owns a 128x8 single-port RAM for the duration of
//             one job. On a start request it reads a block of consecutive
//             bytes, accumulates their 16-bit sum, and writes the sum back as
//             two bytes (low byte at dst, high byte at dst+1). A one-cycle
//             done pulse marks completion, and the result stays on sum.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   clock; every register updates on the rising edge
//    reset     in   synchronous active-high reset
//    start     in   request pulse; only accepted while idle
//    src_addr  in   first byte address of the block (captured on accept)
//    length    in   byte count 0..255 (captured on accept)
//    dst_addr  in   result address; high byte goes to dst_addr+1 (captured)
//    ram_q     in   RAM read data, combinational from ram_addr
//    ram_addr  out  RAM address
//    ram_data  out  RAM write data
//    ram_en    out  RAM write enable; the write lands on the next rising edge
//    busy      out  high whenever a job is in progress
//    done      out  one-cycle completion pulse
//    sum       out  result of the last completed job
// ============================================================================
module ram_block_summer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int SUM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Zero-extension width for adding a RAM byte into the accumulator.
  localparam int PAD_W = SUM_W - DATA_W;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  idx_q,   idx_d;
  logic [SUM_W-1:0]  acc_q,   acc_d;
  logic [SUM_W-1:0]  sum_q,   sum_d;
  logic [ADDR_W-1:0] src_q,   src_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [ADDR_W-1:0] dst_q,   dst_d;

  // Helper combinational signals
  logic              job_active;
  logic              last_read;
  logic [ADDR_W-1:0] read_addr;
  logic [ADDR_W-1:0] dst_hi_addr;

  // A job is "active" from the first READ cycle up to and including DONE.
  // Reset in this window aborts the job but must not disturb the last result.
  assign job_active = (state_q == S_READ)  || (state_q == S_WR_LO) ||
                      (state_q == S_WR_HI) || (state_q == S_DONE);

  // The index only ever reaches len-1 inside READ, so this compare is safe
  // even though len-1 underflows for len==0 (READ is never entered then).
  assign last_read   = (idx_q == (len_q - LEN_W'(1)));

  // Address arithmetic wraps naturally at the ADDR_W boundary; the index is
  // truncated so blocks longer than the RAM re-read earlier bytes.
  assign read_addr   = src_q + ADDR_W'(idx_q);
  assign dst_hi_addr = dst_q + ADDR_W'(1);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    src_d   = src_q;
    len_d   = len_q;
    dst_d   = dst_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          len_d   = length;
          dst_d   = dst_addr;
          acc_d   = '0;
          idx_d   = '0;
          // An empty block skips straight to writing a zero result.
          state_d = (length != '0) ? S_READ : S_WR_LO;
        end
      end

      S_READ: begin
        acc_d = acc_q + {{PAD_W{1'b0}}, ram_q};
        idx_d = idx_q + LEN_W'(1);
        if (last_read) begin
          state_d = S_WR_LO;
        end
      end

      S_WR_LO: begin
        state_d = S_WR_HI;
      end

      S_WR_HI: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result register: loaded as DONE is entered so that it is already valid
  // in the cycle where done is high. Reset clears it only when no job is in
  // flight; an abort keeps the previous result visible.
  always_comb begin
    sum_d = sum_q;
    if (state_q == S_WR_HI) begin
      sum_d = acc_q;
    end
    if (reset) begin
      sum_d = job_active ? sum_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      src_q   <= src_d;
      len_q   <= len_d;
      dst_q   <= dst_d;
    end
  end

  // Reset behaviour for sum is folded into sum_d above.
  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  // --------------------------------------------------------------------------
  // Moore output decode: RAM-side outputs depend only on registered state,
  // so there is no combinational path from ram_q to any output.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end

      S_READ: begin
        ram_addr = read_addr;
      end

      S_WR_LO: begin
        ram_addr = dst_q;
        ram_data = acc_q[DATA_W-1:0];
        ram_en   = 1'b1;
      end

      S_WR_HI: begin
        ram_addr = dst_hi_addr;
        ram_data = acc_q[2*DATA_W-1:DATA_W];
        ram_en   = 1'b1;
      end

      S_DONE: begin
        done = 1'b1;
      end

      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sum = sum_q;

endmodule
`default_nettype wire

// File: doc/ram_block_summer.md
Name: ram_block_summer

Overview:
- Initiator/controller for the 128x8 single-port RAM; drives the RAM's addr/data/write-enable inputs and consumes its combinational read output.
- On a start request, reads a block of consecutive bytes, accumulates a 16-bit sum, writes the sum back as two bytes (low, then high) at a destination address, and reports completion.
- Sits between control logic and the RAM instance; it is the only RAM master while busy.

Parameters:
- ADDR_W, 7, RAM address width (128 entries); all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, RAM data width.
- LEN_W, 8, width of the block length field.
- SUM_W, 16, accumulator width; a 255-byte block of 0xFF sums to 65025, so it cannot overflow.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  request pulse; accepted only in IDLE.
- src_addr  in  ADDR_W  first byte address of the block; captured on accept.
- length  in  LEN_W  byte count, 0..255; captured on accept.
- dst_addr  in  ADDR_W  result address; low byte goes here, high byte at dst_addr+1 mod 128; captured on accept.
- ram_q  in  DATA_W  RAM read data; combinational from ram_addr in the same cycle.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_en  out  1  RAM write enable; the write lands on the next posedge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- sum  out  SUM_W  last completed result; held until the next completion.

Behaviour:
- States: IDLE, READ, WR_LO, WR_HI, DONE.
- Reset: state=IDLE; idx=0; acc=0; sum=0; done=0; busy=0; ram_en=0; ram_addr=0; ram_data=0.
- RAM-side outputs are a Moore decode of the registered state, idx and captured fields. No combinational path from ram_q to any output.
- IDLE:
  - ram_en=0, ram_addr=0, ram_data=0.
  - On start=1, capture src, len, dst; clear acc and idx.
  - Go to READ if len!=0, otherwise go to WR_LO with acc=0.
- READ:
  - ram_addr = src+idx (mod 128), ram_en=0.
  - Each posedge: acc <= acc + zero-extended ram_q; idx++.
  - After the read with idx==len-1, go to WR_LO.
  - Addresses wrap past 127 to 0. len>128 re-reads earlier bytes; this is legal.
- WR_LO: ram_addr=dst, ram_data=acc[7:0], ram_en=1 -> WR_HI.
- WR_HI: ram_addr=dst+1 mod 128 (dst=127 wraps to 0), ram_data=acc[15:8], ram_en=1 -> DONE.
- DONE: done=1 for exactly this cycle; sum <= acc on entry to DONE (sum is valid when done is seen); ram_en=0 -> IDLE.
- Latency, with start sampled at edge 0:
  - READ occupies cycles 1..L; WR_LO is cycle L+1; WR_HI is cycle L+2; done is high in cycle L+3.
  - L=0: done is high in cycle 3.
  - The next start is accepted in cycle L+4.
- start while busy: ignored, not queued; captured fields stay unchanged.
- Overlapping src/dst ranges: all reads complete before any write, so the sum reflects pre-write contents.
- Reset mid-operation: IDLE on the next edge, no done pulse, sum keeps its previous value. A reset after WR_LO's edge leaves only the low byte written; this is accepted behaviour.
- Input changes on src_addr/length/dst_addr after accept have no effect.

Test Plan:
- Preload RAM[10..13]=0x01,0x02,0x03,0x04; start src=10 len=4 dst=33 -> reads at addr 10,11,12,13 in cycles 1-4; ram_en high in cycles 5-6; RAM[33]=0x0A, RAM[34]=0x00; done pulse in cycle 7; sum=0x000A.
- RAM[0..127]=0xFF; start src=0 len=128 dst=36 -> RAM[36]=0x80, RAM[37]=0x7F (sum 0x7F80=32640); busy for 131 cycles.
- Wrap: RAM[126]=0x10, RAM[127]=0x20, RAM[0]=0x30; start src=126 len=3 dst=127 -> read addrs 126,127,0; but RAM[0] is read before the writes, so sum=0x0060; RAM[127]=0x60, RAM[0]=0x00.
- len=0, dst=5 -> no read cycles; RAM[5]=RAM[6]=0x00; done in cycle 3; sum=0.
- Second start pulsed in cycle 2 of a len=4 job with different fields -> ignored; only one done; result matches the first job's fields.
- Assert reset during READ of a len=8 job -> next cycle busy=0, ram_en=0, no done, sum unchanged, RAM at dst unchanged; a new start then completes normally.
